divider_ctrl: RTL and testbench
===============================

# divider_ctrl

Sequencing controller for the 32-bit shift-subtract (restoring) divider datapath. It drives the load, subtract, shift and final-correction strobes of the divisor register, ALU and remainder register. It consumes two status flags from the datapath and signals completion to the issuing stage. There is one controller per divider instance, and it is the only master of the datapath control lines.

## Interface
- WIDTH, 32, operand width; the number of quotient iterations.
- clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high.
- start  in  1  request a division; sampled only in IDLE.
- divisor_zero  in  1  datapath flag, divisor register == 0; sampled in LOAD.
- alu_msb  in  1  sign bit of (remainder_hi − divisor); valid in SUB.
- dp_reset  out  1  datapath register init strobe; paired with W_ctrl.
- W_ctrl  out  1  datapath load strobe.
- shift_en  out  1  shift the 2×WIDTH remainder register left by 1.
- quot_bit  out  1  bit inserted at remainder LSB when shift_en=1.
- rem_we  out  1  write ALU result into remainder_hi.
- hi_shr  out  1  final correction: shift remainder_hi right by 1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  sticky divide-by-zero flag.

## Operation
- States: IDLE, LOAD, INIT, SUB, SHIFT, FIX, DONE.
- IDLE:
  - Wait for start; start=1 → LOAD.
  - start is ignored in every other state; there is no queueing.
- LOAD:
  - dp_reset=1 and W_ctrl=1 for exactly this cycle, so the datapath captures dividend and divisor.
  - div_zero is cleared here.
  - If divisor_zero=1 → DONE with div_zero set; no shift or write strobes are issued.
  - Otherwise → INIT.
- INIT: shift_en=1, quot_bit=0 (pre-shift) → SUB.
- SUB:
  - rem_we = ~alu_msb (combinational from the input).
  - q_reg ← ~alu_msb.
  - → SHIFT.
- SHIFT:
  - shift_en=1, quot_bit=q_reg.
  - If cnt == WIDTH−1: cnt ← 0 and → FIX.
  - Otherwise cnt ← cnt+1 and → SUB.
- FIX: hi_shr=1 → DONE.
- DONE: done=1 → IDLE. div_zero holds until the next LOAD.
- Counter:
  - Width is $clog2(WIDTH) bits; it counts 0..WIDTH−1 and never wraps past WIDTH−1.
  - It is cleared in IDLE and LOAD.
- Strobes are mutually exclusive. At most one of {W_ctrl, shift_en, rem_we, hi_shr} is high in any cycle.
- dp_reset and W_ctrl are always equal. Both are 0 outside LOAD, which makes the datapath registers present their stored values.
- All outputs are decoded from the registered state plus alu_msb (for rem_we only). No other combinational input-to-output paths exist.

## Timing
- Reset (any state, any cycle):
  - The next state is IDLE.
  - cnt=0, q_reg=0, div_zero=0.
  - All outputs are 0 in the cycle after the Reset edge.
  - A division in progress is abandoned, and the datapath contents are don't-care.
- Cycle numbering: start is sampled at edge 0.
  - LOAD: cycle 1.
  - INIT: cycle 2.
  - SUB/SHIFT pairs: cycles 3..2·WIDTH+2.
  - FIX: cycle 2·WIDTH+3.
  - DONE: cycle 2·WIDTH+4, which is cycle 68 for WIDTH=32.
- Divide-by-zero path: LOAD at cycle 1, DONE at cycle 2, div_zero=1 from cycle 2 onward.
- Back-to-back: with start held high, the next LOAD is at DONE+2. IDLE always lasts at least one cycle.
- Reset and start high in the same cycle: Reset wins.

## Structure
- Shared package div_pkg:
  - state enum div_state_t.
  - DIV_WIDTH=32 default.
  - ITER_CNT_W=$clog2(DIV_WIDTH).
- Sub-module div_iter_counter:
  - Inputs: clear, inc.
  - Output: last (cnt == WIDTH−1).
  - Synchronous Reset.
- The FSM and output decode stay in divider_ctrl.

## Test plan
- 100 ÷ 7 with behavioural datapath model → quotient 14, remainder 2. done exactly at cycle 68. busy high for cycles 1–68.
- Divisor 0 → DONE at cycle 2, div_zero=1. shift_en, rem_we and hi_shr never assert. div_zero clears at the next LOAD.
- 0xFFFFFFFF ÷ 1 → quotient 0xFFFFFFFF, remainder 0. quot_bit=1 and rem_we=1 in all 32 iterations.
- start pulsed at cycles 5 and 40 during a busy division → ignored. A single done pulse arrives at cycle 68.
- Reset asserted during the SUB of iteration 10 → all outputs 0 and state IDLE next cycle. A new 100 ÷ 7 then completes correctly at start+68.
- start held high continuously for two divisions → second LOAD two cycles after the first done. Both results are correct, and the one-hot strobe assertion holds throughout.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and sizing for the restoring-divider sequencing controller.
package div_pkg;
  localparam int DIV_WIDTH  = 32;
  localparam int ITER_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_INIT,
    S_SUB,
    S_SHIFT,
    S_FIX,
    S_DONE
  } div_state_t;
endpackage

// File: rtl/div_iter_counter.sv
// Quotient-iteration counter: counts 0..WIDTH-1, flags the final iteration.
module div_iter_counter
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic clk,
  input  logic Reset,
  input  logic clear_i,
  input  logic inc_i,
  output logic last_o
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturate at LAST so a stray increment can never wrap the count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == LAST);
endmodule

// File: rtl/divider_ctrl.sv
// Sequencing controller for the shift-subtract (restoring) divider datapath.
module divider_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic clk,
  input  logic Reset,
  input  logic start,
  input  logic divisor_zero,
  input  logic alu_msb,
  output logic dp_reset,
  output logic W_ctrl,
  output logic shift_en,
  output logic quot_bit,
  output logic rem_we,
  output logic hi_shr,
  output logic busy,
  output logic done,
  output logic div_zero
);
  div_state_t state_q;
  logic       quot_q;
  logic       div_zero_q;
  logic       cnt_last;
  logic       cnt_clear;
  logic       cnt_inc;

  assign cnt_clear = (state_q == S_IDLE) || (state_q == S_LOAD) ||
                     ((state_q == S_SHIFT) && cnt_last);
  assign cnt_inc   = (state_q == S_SHIFT) && !cnt_last;

  div_iter_counter #(.WIDTH(WIDTH)) u_iter_cnt (
    .clk    (clk),
    .Reset  (Reset),
    .clear_i(cnt_clear),
    .inc_i  (cnt_inc),
    .last_o (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      quot_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_q <= S_LOAD;
        S_LOAD: begin
          // A zero divisor skips the iterations entirely; the flag stays until the next LOAD.
          div_zero_q <= divisor_zero;
          state_q    <= divisor_zero ? S_DONE : S_INIT;
        end
        S_INIT:  state_q <= S_SUB;
        S_SUB: begin
          quot_q  <= ~alu_msb;
          state_q <= S_SHIFT;
        end
        S_SHIFT: state_q <= cnt_last ? S_FIX : S_SUB;
        S_FIX:   state_q <= S_DONE;
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Output decode from the registered state; rem_we alone also looks at alu_msb.
  assign dp_reset = (state_q == S_LOAD);
  assign W_ctrl   = (state_q == S_LOAD);
  assign shift_en = (state_q == S_INIT) || (state_q == S_SHIFT);
  assign quot_bit = (state_q == S_SHIFT) && quot_q;
  assign rem_we   = (state_q == S_SUB) && !alu_msb;
  assign hi_shr   = (state_q == S_FIX);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign div_zero = div_zero_q;
endmodule

// File: tb/tb_divider_ctrl.sv
// Scoreboard bench for divider_ctrl driving a behavioural restoring-divider datapath.
module tb_divider_ctrl;
  logic clk = 1'b0;
  logic Reset = 1'b1;
  logic start = 1'b0;
  logic divisor_zero;
  logic alu_msb;
  logic dp_reset, W_ctrl, shift_en, quot_bit, rem_we, hi_shr, busy, done, div_zero;

  logic [31:0] dvd = 32'd0;
  logic [31:0] dvs = 32'd0;

  always #5 clk = ~clk;

  divider_ctrl #(.WIDTH(32)) dut (
    .clk         (clk),
    .Reset       (Reset),
    .start       (start),
    .divisor_zero(divisor_zero),
    .alu_msb     (alu_msb),
    .dp_reset    (dp_reset),
    .W_ctrl      (W_ctrl),
    .shift_en    (shift_en),
    .quot_bit    (quot_bit),
    .rem_we      (rem_we),
    .hi_shr      (hi_shr),
    .busy        (busy),
    .done        (done),
    .div_zero    (div_zero)
  );

  // Behavioural datapath: 64-bit remainder register, divisor register, 33-bit subtractor.
  logic [63:0] rem_m = '0;
  logic [31:0] dvs_m = '0;
  logic [32:0] diff;
  assign diff         = {1'b0, rem_m[63:32]} - {1'b0, dvs_m};
  assign alu_msb      = diff[32];
  assign divisor_zero = (dvs == 32'd0);

  always @(posedge clk) begin
    if (W_ctrl) begin
      rem_m <= {32'd0, dvd};
      dvs_m <= dvs;
    end else if (shift_en) begin
      rem_m <= {rem_m[62:0], quot_bit};
    end else if (rem_we) begin
      rem_m[63:32] <= diff[31:0];
    end else if (hi_shr) begin
      rem_m[63:32] <= rem_m[63:32] >> 1;
    end
  end

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  typedef struct {
    logic [31:0] quot;
    logic [31:0] rem;
    bit          dz;
    int          done_edge;
    int          nshift;
    int          nq;
    int          nr;
    int          nhi;
    int          nbusy;
  } exp_t;

  exp_t sb[$];
  bit   finish_req = 1'b0;

  // ---------------- monitor / checker ----------------
  int n_tests = 0;
  int n_fail  = 0;
  bit rst_pend = 1'b1;
  bit inflight = 1'b0;
  bit dz_m = 1'b0;
  int t_shift, t_q, t_r, t_hi, t_busy;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (finish_req) begin
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end else if (rst_pend) begin
      chk("reset_outputs",
          64'({dp_reset, W_ctrl, shift_en, quot_bit, rem_we, hi_shr, busy, done, div_zero}), 64'd0);
      dz_m = 1'b0;
      if (inflight && sb.size() > 0) void'(sb.pop_front());
      inflight = 1'b0;
    end else begin
      chk("strobe_onehot", 64'($countones({W_ctrl, shift_en, rem_we, hi_shr}) <= 1), 64'd1);
      chk("dp_reset_eq_W_ctrl", 64'(dp_reset), 64'(W_ctrl));
      chk("div_zero_sticky", 64'(div_zero), 64'(dz_m));
      if (W_ctrl) begin
        chk("load_expected", 64'(sb.size() > 0), 64'd1);
        dz_m     = (sb.size() > 0) ? sb[0].dz : 1'b0;
        inflight = 1'b1;
        t_shift = 0; t_q = 0; t_r = 0; t_hi = 0; t_busy = 0;
      end
      t_shift += int'(shift_en);
      t_q     += int'(shift_en && quot_bit);
      t_r     += int'(rem_we);
      t_hi    += int'(hi_shr);
      t_busy  += int'(busy);
      if (done) begin
        chk("done_expected", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          inflight = 1'b0;
          chk("done_cycle", 64'(edge_cnt), 64'(e.done_edge));
          chk("div_zero_at_done", 64'(div_zero), 64'(e.dz));
          chk("shift_count", 64'(t_shift), 64'(e.nshift));
          chk("quot_bit_count", 64'(t_q), 64'(e.nq));
          chk("rem_we_count", 64'(t_r), 64'(e.nr));
          chk("hi_shr_count", 64'(t_hi), 64'(e.nhi));
          chk("busy_cycles", 64'(t_busy), 64'(e.nbusy));
          if (!e.dz) begin
            chk("quotient", 64'(rem_m[31:0]), 64'(e.quot));
            chk("remainder", 64'(rem_m[63:32]), 64'(e.rem));
          end
        end
      end
      if (sb.size() > 0 && edge_cnt > sb[0].done_edge) begin
        chk("done_timeout", 64'(edge_cnt), 64'(sb[0].done_edge));
        void'(sb.pop_front());
        inflight = 1'b0;
      end
    end
    rst_pend = Reset;
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (edge_cnt < target) step(1);
  endtask

  task automatic push_exp(input logic [31:0] q, input logic [31:0] r, input bit dz,
                          input int nq, input int done_edge);
    exp_t e;
    e.quot = q; e.rem = r; e.dz = dz; e.done_edge = done_edge;
    e.nshift = dz ? 0 : 33;
    e.nq     = nq;
    e.nr     = nq;
    e.nhi    = dz ? 0 : 1;
    e.nbusy  = dz ? 2 : 68;
    sb.push_back(e);
  endtask

  // Raise start now; it is sampled at the next edge. Returns the edge at which done is due.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q,
                       input logic [31:0] r, input bit dz, input int nq, output int done_edge);
    dvd = a;
    dvs = b;
    start = 1'b1;
    done_edge = edge_cnt + (dz ? 2 : 68);
    push_exp(q, r, dz, nq, done_edge);
  endtask

  initial begin
    int d1;
    int s0;
    // Reset held with start high: reset must win.
    Reset = 1'b1; start = 1'b1; dvd = 32'd100; dvs = 32'd7;
    step(3);
    Reset = 1'b0; start = 1'b0;
    step(2);

    // 100 / 7 = 14 r 2; quotient 0b1110 has three set bits.
    issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 3, d1);
    step(1); start = 1'b0;
    wait_until(d1 + 3);

    // Divide by zero.
    issue(32'd5, 32'd0, 32'd0, 32'd0, 1'b1, 0, d1);
    step(1); start = 1'b0;
    wait_until(d1 + 4);

    // 1000 / 33 = 30 r 10 (div_zero must have cleared at this LOAD).
    issue(32'd1000, 32'd33, 32'd30, 32'd10, 1'b0, 4, d1);
    step(1); start = 1'b0;
    wait_until(d1 + 3);

    // 0xFFFFFFFF / 1: every iteration subtracts.
    issue(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 32, d1);
    step(1); start = 1'b0;
    wait_until(d1 + 3);

    // start pulses at cycles 5 and 40 of a busy division are ignored.
    s0 = edge_cnt;
    issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 3, d1);
    step(1); start = 1'b0;
    wait_until(s0 + 5);  start = 1'b1;
    step(1);             start = 1'b0;
    wait_until(s0 + 40); start = 1'b1;
    step(1);             start = 1'b0;
    wait_until(d1 + 6);

    // Reset during the SUB of iteration 10 (cycle 21), then a clean division.
    s0 = edge_cnt;
    issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 3, d1);
    step(1); start = 1'b0;
    wait_until(s0 + 21);
    Reset = 1'b1;
    step(1);
    Reset = 1'b0;
    step(2);
    issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 3, d1);
    step(1); start = 1'b0;
    wait_until(d1 + 3);

    // start held high: second LOAD two cycles after the first done.
    issue(32'd1000, 32'd33, 32'd30, 32'd10, 1'b0, 4, d1);
    step(3);
    dvd = 32'd100;
    dvs = 32'd7;
    push_exp(32'd14, 32'd2, 1'b0, 3, d1 + 69);
    wait_until(d1 + 2);
    start = 1'b0;
    wait_until(d1 + 69 + 4);

    finish_req = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
endmodule
